// File: rtl/sm_seq_mult_if.sv
// Operand/result handshake bundle for the sign-magnitude sequential multiplier.
interface sm_seq_mult_if #(
   parameter int WIDTH = 5
);
   localparam int MW = WIDTH - 1;

   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] number1_i;
   logic [WIDTH-1:0] number2_i;
   logic             valid_o;
   logic             ready_i;
   logic [2*MW:0]    mult_o;

   modport master (
      output valid_i, number1_i, number2_i, ready_i,
      input  ready_o, valid_o, mult_o
   );

   modport slave (
      input  valid_i, number1_i, number2_i, ready_i,
      output ready_o, valid_o, mult_o
   );
endinterface

// File: rtl/sm_seq_mult.sv
// Sign-magnitude shift-add multiplier. The result is valid exactly WIDTH-1 edges after accept.
// Operands are accepted only in IDLE. The result is held in DONE until ready_i is seen.
module sm_seq_mult #(
   parameter int WIDTH = 5
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   sm_seq_mult_if.slave  bus
);
   localparam int MW = WIDTH - 1;
   localparam int CW = (MW > 1) ? $clog2(MW) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MW - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state, state_nxt;
   logic [2*MW-1:0] acc, mcand, acc_sum;
   logic [MW-1:0]   mplier;
   logic [CW-1:0]   cnt;
   logic            sign;
   logic [2*MW:0]   mult_q;
   logic            accept, last_step;

   assign accept    = (state == IDLE) && bus.valid_i;
   assign last_step = (state == BUSY) && (cnt == CNT_LAST);
   assign acc_sum   = mplier[0] ? (acc + mcand) : acc;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.valid_i) state_nxt = BUSY;
         BUSY:    if (last_step)   state_nxt = DONE;
         DONE:    if (bus.ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.ready_o = (state == IDLE);
      bus.valid_o = (state == DONE);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         sign   <= 1'b0;
         mult_q <= '0;
      end else if (accept) begin
         acc    <= '0;
         mcand  <= {{MW{1'b0}}, bus.number1_i[MW-1:0]};
         mplier <= bus.number2_i[MW-1:0];
         sign   <= bus.number1_i[MW] ^ bus.number2_i[MW];
         cnt    <= '0;
      end else if (state == BUSY) begin
         acc    <= acc_sum;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         // a zero magnitude always leaves with a positive sign
         if (last_step) mult_q <= {sign & (|acc_sum), acc_sum};
      end
   end

   assign bus.mult_o = mult_q;
endmodule

// File: tb/tb_sm_seq_mult.sv
// Directed and random checks of sm_seq_mult at WIDTH=5 and WIDTH=9.
module tb_sm_seq_mult;
   logic clk_i;
   logic rstn_i;
   int   n_checks = 0;
   int   n_fail   = 0;

   sm_seq_mult_if #(.WIDTH(5)) i5 ();
   sm_seq_mult_if #(.WIDTH(9)) i9 ();

   sm_seq_mult #(.WIDTH(5)) u_dut5 (.clk_i(clk_i), .rstn_i(rstn_i), .bus(i5.slave));
   sm_seq_mult #(.WIDTH(9)) u_dut9 (.clk_i(clk_i), .rstn_i(rstn_i), .bus(i9.slave));

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [8:0] model5(input logic [4:0] a, input logic [4:0] b);
      logic [7:0] mag;
      mag = 8'(a[3:0] * b[3:0]);
      return {(a[4] ^ b[4]) && (mag != 0), mag};
   endfunction

   function automatic logic [16:0] model9(input logic [8:0] a, input logic [8:0] b);
      logic [15:0] mag;
      mag = 16'(a[7:0] * b[7:0]);
      return {(a[8] ^ b[8]) && (mag != 0), mag};
   endfunction

   // Called at a negedge in IDLE; returns at the negedge after leaving DONE (or in DONE if ready_i=0).
   task automatic op5(input logic [4:0] a, input logic [4:0] b, input logic [8:0] exp, input string tag);
      int lat;
      check({tag, "_rdy_idle"}, i5.ready_o, 1);
      i5.valid_i   = 1'b1;
      i5.number1_i = a;
      i5.number2_i = b;
      @(negedge clk_i);
      i5.valid_i   = 1'b0;
      i5.number1_i = 5'($urandom_range(0, 31));
      i5.number2_i = 5'($urandom_range(0, 31));
      check({tag, "_rdy_busy"}, i5.ready_o, 0);
      lat = 0;
      while (!i5.valid_o && lat < 40) begin
         @(negedge clk_i);
         lat++;
      end
      check({tag, "_lat"}, lat, 4);
      check({tag, "_mult"}, i5.mult_o, exp);
      if (i5.ready_i) begin
         @(negedge clk_i);
         check({tag, "_vld_clr"}, i5.valid_o, 0);
      end
   endtask

   task automatic op9(input logic [8:0] a, input logic [8:0] b, input logic [16:0] exp, input string tag);
      int lat;
      check({tag, "_rdy_idle"}, i9.ready_o, 1);
      i9.valid_i   = 1'b1;
      i9.number1_i = a;
      i9.number2_i = b;
      @(negedge clk_i);
      i9.valid_i   = 1'b0;
      i9.number1_i = 9'($urandom_range(0, 511));
      i9.number2_i = 9'($urandom_range(0, 511));
      lat = 0;
      while (!i9.valid_o && lat < 40) begin
         @(negedge clk_i);
         lat++;
      end
      check({tag, "_lat"}, lat, 8);
      check({tag, "_mult"}, i9.mult_o, exp);
      @(negedge clk_i);
      check({tag, "_vld_clr"}, i9.valid_o, 0);
   endtask

   initial begin
      logic [4:0] a5, b5;
      logic [8:0] a9, b9;

      rstn_i = 1'b0;
      i5.valid_i = 1'b0; i5.number1_i = '0; i5.number2_i = '0; i5.ready_i = 1'b1;
      i9.valid_i = 1'b0; i9.number1_i = '0; i9.number2_i = '0; i9.ready_i = 1'b1;
      #2;
      check("rst_rdy5", i5.ready_o, 1);
      check("rst_vld5", i5.valid_o, 0);
      check("rst_mult5", i5.mult_o, 0);
      check("rst_rdy9", i9.ready_o, 1);
      check("rst_vld9", i9.valid_o, 0);
      check("rst_mult9", i9.mult_o, 0);
      @(negedge clk_i);
      rstn_i = 1'b1;
      @(negedge clk_i);

      // T1..T3 directed
      op5(5'b0_0111, 5'b1_0101, 9'h123, "t1");
      op5(5'b0_1111, 5'b0_1111, 9'h0E1, "t2a");
      op5(5'b1_1111, 5'b1_1111, 9'h0E1, "t2b");
      op5(5'b1_0000, 5'b0_0110, 9'h000, "t3a");
      op5(5'b0_0000, 5'b1_0000, 9'h000, "t3b");
      op5(5'b1_0011, 5'b0_0001, 9'h103, "neg3");

      // T4 stall with noise on the operand side
      i5.ready_i = 1'b0;
      op5(5'b0_0111, 5'b1_0101, 9'h123, "t4");
      for (int i = 0; i < 10; i++) begin
         i5.valid_i   = 1'($urandom_range(0, 1));
         i5.number1_i = 5'($urandom_range(0, 31));
         i5.number2_i = 5'($urandom_range(0, 31));
         @(negedge clk_i);
         check("t4_stall_vld", i5.valid_o, 1);
         check("t4_stall_mult", i5.mult_o, 9'h123);
         check("t4_stall_rdy", i5.ready_o, 0);
      end
      i5.valid_i = 1'b0;
      i5.ready_i = 1'b1;
      @(negedge clk_i);
      check("t4_rel_vld", i5.valid_o, 0);
      check("t4_rel_rdy", i5.ready_o, 1);
      check("t4_rel_mult", i5.mult_o, 9'h123);

      // T5 reset two cycles into BUSY
      i5.valid_i = 1'b1; i5.number1_i = 5'b0_1111; i5.number2_i = 5'b0_1111;
      @(negedge clk_i);
      i5.valid_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      #2 rstn_i = 1'b0;
      #1;
      check("t5_rst_rdy", i5.ready_o, 1);
      check("t5_rst_vld", i5.valid_o, 0);
      check("t5_rst_mult", i5.mult_o, 0);
      @(negedge clk_i);
      @(negedge clk_i);
      rstn_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         check("t5_no_stale", i5.valid_o, 0);
      end
      op5(5'b0_0011, 5'b0_0011, 9'h009, "t5_next");

      // reset while a result is waiting in DONE
      i5.ready_i = 1'b0;
      op5(5'b0_0111, 5'b0_0111, 9'h031, "rst_done");
      #2 rstn_i = 1'b0;
      #1;
      check("rst_done_vld", i5.valid_o, 0);
      check("rst_done_mult", i5.mult_o, 0);
      check("rst_done_rdy", i5.ready_o, 1);
      @(negedge clk_i);
      rstn_i = 1'b1;
      i5.ready_i = 1'b1;
      @(negedge clk_i);

      // T6 W=9
      op9(9'h0FF, 9'h1FF, 17'h1FE01, "t6");
      op9(9'h100, 9'h0A5, 17'h00000, "t6_zero");
      op9(9'h00C, 9'h10A, 17'h10078, "t6_neg");

      for (int i = 0; i < 500; i++) begin
         a5 = 5'($urandom_range(0, 31));
         b5 = 5'($urandom_range(0, 31));
         op5(a5, b5, model5(a5, b5), "rnd5");
      end
      for (int i = 0; i < 500; i++) begin
         a9 = 9'($urandom_range(0, 511));
         b9 = 9'($urandom_range(0, 511));
         op9(a9, b9, model9(a9, b9), "rnd9");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
